ahb_resp_mux: RTL
=================

AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 Parameter NS, default 4: number of slave ports, legal range 2..16.
REQ-002 Parameter DW, default 32: read-data width in bits.
REQ-003 Parameter TMO, default 0: wait-state timeout in cycles, legal range 0..255; 0 disables the timeout.
REQ-004 Clock and reset: one clock; reset is synchronous and active-high.
REQ-005 hclk  in  1  bus clock; all state updates on its rising edge.
REQ-006 hrst  in  1  synchronous active-high reset.
REQ-007 sel  in  NS  address-phase slave select, one-hot expected.
REQ-008 htrans  in  2  address-phase transfer type; bit 1 set means NONSEQ or SEQ.
REQ-009 hrdata_in  in  NS*DW  slave read data; slave k occupies bits [k*DW+DW-1 : k*DW].
REQ-010 hreadyout_in  in  NS  per-slave ready.
REQ-011 hresp_in  in  NS  per-slave response; 1 means ERROR.
REQ-012 hrdata  out  DW  muxed read data.
REQ-013 hready  out  1  muxed ready, fed back to all slaves and the master.
REQ-014 hresp  out  1  muxed response.
REQ-015 dsel  out  NS  registered data-phase select.
REQ-016 sel_err  out  1  sticky multi-hot select flag.

Function
REQ-017 Address phase accepted = hready==1 in that cycle; no state changes while hready==0, except the timeout counter and error sequencing.
REQ-018 FSM states: IDLE, DATA, ERR1, ERR2.
REQ-019 On an accepted address phase with htrans[1]==0: next state IDLE, dsel cleared to 0.
REQ-020 On an accepted address phase with htrans[1]==1 and sel one-hot: next state DATA, dsel latched from sel.
REQ-021 On an accepted address phase with htrans[1]==1 and sel zero or multi-hot: next state ERR1, dsel cleared to 0.
REQ-022 A multi-hot sel on an accepted active transfer sets sel_err; sel_err stays set until reset.
REQ-023 IDLE outputs: hready=1, hresp=0, hrdata=0.
REQ-024 DATA outputs: AND-OR of dsel with hrdata_in, hreadyout_in and hresp_in, with zero added latency.
REQ-025 ERR1 outputs: hready=0, hresp=1, hrdata=0; next state is always ERR2.
REQ-026 ERR2 outputs: hready=1, hresp=1, hrdata=0; an address phase is accepted in this cycle per REQ-019..021.
REQ-027 Timeout counter width is 8 bits; it clears on entry to DATA and whenever the selected hreadyout_in==1.
REQ-028 The counter increments each DATA cycle with the selected hreadyout_in==0.
REQ-029 With TMO!=0 and counter==TMO-1 while the selected hreadyout_in==0: next state ERR1, dsel cleared; later responses from the abandoned slave are ignored.
REQ-030 With TMO==0, DATA may stall indefinitely.
REQ-031 If the slave completes (hreadyout_in==1) in the same cycle the timeout would fire, the slave response wins.
REQ-032 Back-to-back transfers need no idle cycle; DATA to DATA switches dsel on the completing cycle.

Reset
REQ-033 While hrst==1 at a hclk edge: state=IDLE, dsel=0, counter=0, sel_err=0.
REQ-034 Outputs in the cycle after reset: hready=1, hresp=0, hrdata=0.
REQ-035 Reset asserted mid-transfer or mid-ERR1/ERR2 abandons the transfer; no error phase completes after reset.

Structure
REQ-036 Shared package ahb_pkg holds: state encoding, the HTRANS constants IDLE/BUSY/NONSEQ/SEQ, the HRESP constants OKAY/ERROR, and the timeout counter width constant.
REQ-037 One sub-module, onehot_mux (parameters NS, DW; NS-input AND-OR one-hot mux), is instantiated for hrdata; ready and response use the same sub-module with DW=1.
REQ-038 The onehot_mux sub-module is purely combinational; all sequential logic resides in ahb_resp_mux.

Verification
REQ-039 Reset, then sel=4'b0010, htrans=2'b10, slave1 hrdata=32'hDEAD_BEEF, ready=1 -> next cycle hrdata=32'hDEAD_BEEF, hready=1, hresp=0, dsel=4'b0010.
REQ-040 sel=0, htrans=2'b10 -> next two cycles {hready,hresp} = {0,1} then {1,1}; sel_err stays 0.
REQ-041 sel=4'b0101, htrans=2'b11 -> two-cycle ERROR as REQ-040; sel_err=1, held after 10 further IDLE cycles.
REQ-042 TMO=4, slave2 selected holding hreadyout_in=0 -> hready=0 for 4 DATA cycles, then ERR1/ERR2; variant with the slave readying on the 4th cycle -> OKAY, no error.
REQ-043 Back-to-back slave0 then slave3 with slave0 waiting 2 cycles -> dsel changes only on slave0's completing cycle; slave3 data appears one cycle later.
REQ-044 hrst pulsed during ERR1 -> next cycle hready=1, hresp=0, dsel=0, state IDLE.

Source files
------------

// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB constants, response-mux state encoding and select helper
package ahb_pkg;

    // Response-mux FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

    // HTRANS encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // HRESP encodings
    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Width of the wait-state timeout counter
    localparam int TMO_CW = 8;

    // Number of set bits in a select vector (zero-extended to 16 bits)
    function automatic logic [4:0] sel_count(input logic [15:0] s);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, s[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/onehot_mux.sv
// rtl/onehot_mux.sv - combinational AND-OR one-hot multiplexer
// Ports:
//   sel  [NS]     one-hot select
//   data [NS*DW]  input k occupies data[k*DW +: DW]
//   y    [DW]     OR of all inputs gated by their select bit
module onehot_mux #(
    parameter int NS = 4,
    parameter int DW = 32
) (
    input  logic [NS-1:0]    sel,
    input  logic [NS*DW-1:0] data,
    output logic [DW-1:0]    y
);

    always_comb begin
        y = '0;
        for (int k = 0; k < NS; k++) begin
            y = y | ({DW{sel[k]}} & data[k*DW +: DW]);
        end
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// rtl/ahb_resp_mux.sv - AHB slave-to-master response multiplexer with default-slave error and timeout
// Ports:
//   hclk, hrst                 clock, synchronous active-high reset
//   sel, htrans                address-phase slave select and transfer type
//   hrdata_in, hreadyout_in,
//   hresp_in                   per-slave data-phase response signals
//   hrdata, hready, hresp      muxed response to the master (hready also fed back to slaves)
//   dsel                       registered data-phase select
//   sel_err                    sticky flag: an active transfer was seen with multi-hot sel
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int NS  = 4,
    parameter int DW  = 32,
    parameter int TMO = 0
) (
    input  logic             hclk,
    input  logic             hrst,
    input  logic [NS-1:0]    sel,
    input  logic [1:0]       htrans,
    input  logic [NS*DW-1:0] hrdata_in,
    input  logic [NS-1:0]    hreadyout_in,
    input  logic [NS-1:0]    hresp_in,
    output logic [DW-1:0]    hrdata,
    output logic             hready,
    output logic             hresp,
    output logic [NS-1:0]    dsel,
    output logic             sel_err
);

    localparam logic                TMO_EN   = (TMO != 0);
    // Counter value on the last permitted wait cycle
    localparam logic [TMO_CW-1:0] TMO_LAST = TMO_CW'((TMO == 0) ? 0 : TMO - 1);

    state_t            state;
    logic [TMO_CW-1:0] cnt;

    logic [DW-1:0] mux_rdata;
    logic          mux_ready;
    logic          mux_resp;
    logic [4:0]    sel_cnt;
    logic          active;

    onehot_mux #(.NS(NS), .DW(DW)) u_rdata_mux (
        .sel  (dsel),
        .data (hrdata_in),
        .y    (mux_rdata)
    );

    onehot_mux #(.NS(NS), .DW(1)) u_ready_mux (
        .sel  (dsel),
        .data (hreadyout_in),
        .y    (mux_ready)
    );

    onehot_mux #(.NS(NS), .DW(1)) u_resp_mux (
        .sel  (dsel),
        .data (hresp_in),
        .y    (mux_resp)
    );

    assign sel_cnt = sel_count(16'(sel));
    assign active  = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

    // Outputs follow the state; in DATA the selected slave drives them directly
    always_comb begin
        hready = 1'b1;
        hresp  = HRESP_OKAY;
        hrdata = '0;
        case (state)
            ST_DATA: begin
                hready = mux_ready;
                hresp  = mux_resp;
                hrdata = mux_rdata;
            end
            ST_ERR1: begin
                hready = 1'b0;
                hresp  = HRESP_ERROR;
            end
            ST_ERR2: begin
                hready = 1'b1;
                hresp  = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hrst) begin
            state   <= ST_IDLE;
            dsel    <= '0;
            cnt     <= '0;
            sel_err <= 1'b0;
        end else begin
            case (state)
                ST_ERR1: state <= ST_ERR2;
                ST_DATA: begin
                    // Wait state: count it, or abandon the slave once the budget is spent
                    if (!mux_ready) begin
                        if (TMO_EN && cnt == TMO_LAST) begin
                            state <= ST_ERR1;
                            dsel  <= '0;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + TMO_CW'(1);
                        end
                    end
                end
                default: ;
            endcase

            // Address phase is accepted whenever hready is high (never in ERR1)
            if (state != ST_ERR1 && hready) begin
                cnt <= '0;
                if (!active) begin
                    state <= ST_IDLE;
                    dsel  <= '0;
                end else if (sel_cnt == 5'd1) begin
                    state <= ST_DATA;
                    dsel  <= sel;
                end else begin
                    state <= ST_ERR1;
                    dsel  <= '0;
                    if (sel_cnt > 5'd1) begin
                        sel_err <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
